// File: rtl/id_ex_skid_pkg.sv
// Shared constants for the ID/EX skid register: NOP payload encodings,
// default bus widths and the occupancy state encoding.
package id_ex_skid_pkg;

    localparam int ALUSEL_BUS_W   = 3;
    localparam int ALUOP_BUS_W    = 8;
    localparam int REG_BUS_W      = 32;
    localparam int REG_ADDR_BUS_W = 5;

    localparam logic [2:0] EXE_RES_NOP = 3'b000;
    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/id_ex_skid_ctrl.sv
// Occupancy FSM for the ID/EX skid register: tracks main/skid validity,
// produces the registered id_ready and the payload load/shift/clear enables.
import id_ex_skid_pkg::*;

module id_ex_skid_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic id_valid,
    input  logic ex_ready,
    output logic id_ready,
    output logic main_valid,
    output logic load_main_in,
    output logic load_main_skid,
    output logic load_skid,
    output logic clear_main,
    output logic clear_skid
);

    skid_state_t state, next_state;
    logic        in_fire;
    logic        out_fire;

    assign main_valid = (state != EMPTY);
    assign in_fire    = id_valid & id_ready;
    assign out_fire   = main_valid & ex_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            id_ready <= 1'b1;
        end else begin
            state    <= next_state;
            id_ready <= (next_state != TWO);
        end
    end

    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        clear_main     = 1'b0;
        clear_skid     = 1'b0;
        // flush wins over both handshakes and drops the incoming entry
        if (flush) begin
            next_state = EMPTY;
            clear_main = 1'b1;
            clear_skid = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        load_main_in = 1'b1;
                        next_state   = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        load_skid  = 1'b1;
                        next_state = TWO;
                    end else if (out_fire) begin
                        clear_main = 1'b1;
                        next_state = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        load_main_skid = 1'b1;
                        clear_skid     = 1'b1;
                        next_state     = ONE;
                    end
                end
                default: begin
                    next_state = EMPTY;
                    clear_main = 1'b1;
                    clear_skid = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/id_ex_skid.sv
// ID/EX pipeline register with a 2-entry skid buffer so EX can stall without a
// combinational ready path into ID; includes a saturating stall-cycle counter.
import id_ex_skid_pkg::*;

module id_ex_skid #(
    parameter int ALUSEL_W = ALUSEL_BUS_W,
    parameter int ALUOP_W  = ALUOP_BUS_W,
    parameter int DATA_W   = REG_BUS_W,
    parameter int ADDR_W   = REG_ADDR_BUS_W,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [ALUSEL_W-1:0] id_alusel,
    input  logic [ALUOP_W-1:0]  id_aluop,
    input  logic [DATA_W-1:0]   id_opv1,
    input  logic [DATA_W-1:0]   id_opv2,
    input  logic [ADDR_W-1:0]   id_waddr,
    input  logic                id_we,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [ALUSEL_W-1:0] ex_alusel,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [DATA_W-1:0]   ex_opv1,
    output logic [DATA_W-1:0]   ex_opv2,
    output logic [ADDR_W-1:0]   ex_waddr,
    output logic                ex_we,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam logic [ALUSEL_W-1:0] NOP_SEL = ALUSEL_W'(EXE_RES_NOP);
    localparam logic [ALUOP_W-1:0]  NOP_OP  = ALUOP_W'(EXE_NOP_OP);
    localparam logic [CNT_W-1:0]    CNT_MAX = '1;

    logic                load_main_in;
    logic                load_main_skid;
    logic                load_skid;
    logic                clear_main;
    logic                clear_skid;

    logic [ALUSEL_W-1:0] skid_alusel;
    logic [ALUOP_W-1:0]  skid_aluop;
    logic [DATA_W-1:0]   skid_opv1;
    logic [DATA_W-1:0]   skid_opv2;
    logic [ADDR_W-1:0]   skid_waddr;
    logic                skid_we;

    id_ex_skid_ctrl u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .id_valid       (id_valid),
        .ex_ready       (ex_ready),
        .id_ready       (id_ready),
        .main_valid     (ex_valid),
        .load_main_in   (load_main_in),
        .load_main_skid (load_main_skid),
        .load_skid      (load_skid),
        .clear_main     (clear_main),
        .clear_skid     (clear_skid)
    );

    // Main entry: clearing to NOP keeps ex_we low whenever ex_valid is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear_main) begin
            ex_alusel <= NOP_SEL;
            ex_aluop  <= NOP_OP;
            ex_opv1   <= '0;
            ex_opv2   <= '0;
            ex_waddr  <= '0;
            ex_we     <= 1'b0;
        end else if (load_main_skid) begin
            ex_alusel <= skid_alusel;
            ex_aluop  <= skid_aluop;
            ex_opv1   <= skid_opv1;
            ex_opv2   <= skid_opv2;
            ex_waddr  <= skid_waddr;
            ex_we     <= skid_we;
        end else if (load_main_in) begin
            ex_alusel <= id_alusel;
            ex_aluop  <= id_aluop;
            ex_opv1   <= id_opv1;
            ex_opv2   <= id_opv2;
            ex_waddr  <= id_waddr;
            ex_we     <= id_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear_skid) begin
            skid_alusel <= NOP_SEL;
            skid_aluop  <= NOP_OP;
            skid_opv1   <= '0;
            skid_opv2   <= '0;
            skid_waddr  <= '0;
            skid_we     <= 1'b0;
        end else if (load_skid) begin
            skid_alusel <= id_alusel;
            skid_aluop  <= id_aluop;
            skid_opv1   <= id_opv1;
            skid_opv2   <= id_opv2;
            skid_waddr  <= id_waddr;
            skid_we     <= id_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (ex_valid && !ex_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_skid.sv
// Bench for id_ex_skid: queue-based occupancy model checked every cycle plus
// directed vectors with literal expectations.
module tb_id_ex_skid;

    localparam int ALUSEL_W = 3;
    localparam int ALUOP_W  = 8;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [ALUSEL_W-1:0] alusel;
        logic [ALUOP_W-1:0]  aluop;
        logic [DATA_W-1:0]   opv1;
        logic [DATA_W-1:0]   opv2;
        logic [ADDR_W-1:0]   waddr;
        logic                we;
    } entry_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic                id_valid;
    logic                id_ready;
    logic [ALUSEL_W-1:0] id_alusel;
    logic [ALUOP_W-1:0]  id_aluop;
    logic [DATA_W-1:0]   id_opv1;
    logic [DATA_W-1:0]   id_opv2;
    logic [ADDR_W-1:0]   id_waddr;
    logic                id_we;
    logic                ex_valid;
    logic                ex_ready;
    logic [ALUSEL_W-1:0] ex_alusel;
    logic [ALUOP_W-1:0]  ex_aluop;
    logic [DATA_W-1:0]   ex_opv1;
    logic [DATA_W-1:0]   ex_opv2;
    logic [ADDR_W-1:0]   ex_waddr;
    logic                ex_we;
    logic [CNT_W-1:0]    stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    entry_t m_q[$];
    logic   m_rdy = 1'b1;
    int     m_cnt = 0;

    id_ex_skid #(
        .ALUSEL_W (ALUSEL_W),
        .ALUOP_W  (ALUOP_W),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_alusel (id_alusel),
        .id_aluop  (id_aluop),
        .id_opv1   (id_opv1),
        .id_opv2   (id_opv2),
        .id_waddr  (id_waddr),
        .id_we     (id_we),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_alusel (ex_alusel),
        .ex_aluop  (ex_aluop),
        .ex_opv1   (ex_opv1),
        .ex_opv2   (ex_opv2),
        .ex_waddr  (ex_waddr),
        .ex_we     (ex_we),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: a FIFO of at most two entries; id_ready means "fewer than two held"
    always begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_q.delete();
            m_rdy = 1'b1;
            m_cnt = 0;
        end else begin
            entry_t e;
            logic   in_f, out_f;
            in_f  = id_valid && m_rdy;
            out_f = (m_q.size() > 0) && ex_ready;
            if (m_q.size() > 0 && !ex_ready && m_cnt < CNT_MAX) m_cnt++;
            if (flush) begin
                m_q.delete();
            end else begin
                if (out_f) void'(m_q.pop_front());
                if (in_f) begin
                    e.alusel = id_alusel; e.aluop = id_aluop; e.opv1 = id_opv1;
                    e.opv2 = id_opv2; e.waddr = id_waddr; e.we = id_we;
                    m_q.push_back(e);
                end
            end
            m_rdy = (m_q.size() < 2);
        end
    end

    always @(negedge clk) begin
        entry_t h;
        logic   v;
        v = (m_q.size() > 0);
        if (v) h = m_q[0];
        else begin
            h.alusel = '0; h.aluop = '0; h.opv1 = '0; h.opv2 = '0; h.waddr = '0; h.we = 1'b0;
        end
        chk("mdl_ex_valid", 64'(ex_valid), 64'(v));
        chk("mdl_id_ready", 64'(id_ready), 64'(m_rdy));
        chk("mdl_alusel", 64'(ex_alusel), 64'(h.alusel));
        chk("mdl_aluop", 64'(ex_aluop), 64'(h.aluop));
        chk("mdl_opv1", 64'(ex_opv1), 64'(h.opv1));
        chk("mdl_opv2", 64'(ex_opv2), 64'(h.opv2));
        chk("mdl_waddr", 64'(ex_waddr), 64'(h.waddr));
        chk("mdl_we", 64'(ex_we), 64'(h.we));
        chk("mdl_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] val);
        id_valid  = v;
        id_opv1   = val;
        id_alusel = ALUSEL_W'(val);
        id_aluop  = ALUOP_W'(val * 3);
        id_opv2   = ~val;
        id_waddr  = ADDR_W'(val + 1);
        id_we     = v;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b0;
        drive(1'b0, '0);
        repeat (3) cyc();
        rst = 1'b0;
        chk("rst_ex_valid", 64'(ex_valid), 64'd0);
        chk("rst_ex_we", 64'(ex_we), 64'd0);
        chk("rst_ex_aluop", 64'(ex_aluop), 64'd0);
        chk("rst_id_ready", 64'(id_ready), 64'd1);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);

        // streaming
        ex_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, DATA_W'(i));
            cyc();
            chk("stream_opv1", 64'(ex_opv1), 64'(i));
            chk("stream_id_ready", 64'(id_ready), 64'd1);
        end
        drive(1'b0, '0);
        cyc();
        chk("bubble_valid", 64'(ex_valid), 64'd0);
        chk("bubble_we", 64'(ex_we), 64'd0);

        // skid fill
        drive(1'b1, 32'hA);
        cyc();
        ex_ready = 1'b0;
        drive(1'b1, 32'hB);
        cyc();
        chk("skid_id_ready", 64'(id_ready), 64'd0);
        chk("skid_hold_a", 64'(ex_opv1), 64'hA);
        chk("skid_cnt1", 64'(stall_cnt), 64'd1);
        drive(1'b0, '0);
        cyc();
        chk("skid_hold_a2", 64'(ex_opv1), 64'hA);
        chk("skid_cnt2", 64'(stall_cnt), 64'd2);
        ex_ready = 1'b1;
        cyc();
        chk("pop_b", 64'(ex_opv1), 64'hB);
        chk("pop_id_ready", 64'(id_ready), 64'd1);
        cyc();
        chk("pop_empty", 64'(ex_valid), 64'd0);

        // flush priority while TWO
        ex_ready = 1'b0;
        drive(1'b1, 32'hD);
        cyc();
        drive(1'b1, 32'hE);
        cyc();
        chk("two_id_ready", 64'(id_ready), 64'd0);
        flush = 1'b1; ex_ready = 1'b1;
        drive(1'b1, 32'hC);
        cyc();
        flush = 1'b0;
        drive(1'b0, '0);
        chk("flush_valid", 64'(ex_valid), 64'd0);
        chk("flush_we", 64'(ex_we), 64'd0);
        chk("flush_opv1", 64'(ex_opv1), 64'd0);
        chk("flush_id_ready", 64'(id_ready), 64'd1);
        cyc();
        chk("flush_no_c", 64'(ex_valid), 64'd0);

        // saturation
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        ex_ready = 1'b0;
        drive(1'b1, 32'hF);
        cyc();
        drive(1'b0, '0);
        repeat (20) cyc();
        chk("sat_cnt", 64'(stall_cnt), 64'd15);
        cyc();
        chk("sat_hold", 64'(stall_cnt), 64'd15);

        // async reset mid-stall in TWO
        drive(1'b1, 32'h6);
        cyc();
        drive(1'b0, '0);
        chk("pre_rst_id_ready", 64'(id_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(ex_valid), 64'd0);
        chk("arst_id_ready", 64'(id_ready), 64'd1);
        chk("arst_opv1", 64'(ex_opv1), 64'd0);
        chk("arst_we", 64'(ex_we), 64'd0);
        chk("arst_cnt", 64'(stall_cnt), 64'd0);
        cyc();
        rst = 1'b0;
        ex_ready = 1'b1;
        cyc();
        chk("post_rst_valid", 64'(ex_valid), 64'd0);
        cyc();
        chk("post_rst_valid2", 64'(ex_valid), 64'd0);
        chk("post_rst_opv1", 64'(ex_opv1), 64'd0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
